// File: rtl/mux_pkg.sv
// Shared definitions for the scanning N-to-1 multiplexer family.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Index width for n values, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = $clog2(n);
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_tree_nto1.sv
// Combinational N-to-1 select tree: radix-4 levels, one radix-2 level when the
// select width is odd. Unpopulated leaves are tied to zero, so any
// out-of-range select yields zero.
module mux_tree_nto1
    import mux_pkg::*;
#(
    parameter int unsigned NCH = 8,
    parameter int unsigned W = 1,
    localparam int unsigned SELW = clog2_min1(NCH)
) (
    input  logic [NCH*W-1:0] a,
    input  logic [SELW-1:0]  sel,
    output logic [W-1:0]     y
);

    localparam int unsigned P    = 32'd1 << SELW;
    localparam int unsigned N4   = SELW / 2;
    localparam int unsigned N2   = SELW % 2;
    localparam int unsigned NLVL = N4 + N2;

    logic [W-1:0] node [0:NLVL][0:P-1];

    // Leaf level, padded to a power of two with zeros.
    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < NCH) begin : g_in
            assign node[0][i] = a[i*W +: W];
        end else begin : g_pad
            assign node[0][i] = '0;
        end
    end

    for (genvar l = 1; l <= N4; l++) begin : g_l4
        localparam int unsigned CNT = P >> (2 * l);
        for (genvar j = 0; j < P; j++) begin : g_n
            if (j < CNT) begin : g_mux
                logic [1:0] s;
                assign s = sel[2*(l-1) +: 2];
                assign node[l][j] = s[1] ? (s[0] ? node[l-1][4*j+3] : node[l-1][4*j+2])
                                         : (s[0] ? node[l-1][4*j+1] : node[l-1][4*j]);
            end else begin : g_zero
                assign node[l][j] = '0;
            end
        end
    end

    if (N2 == 1) begin : g_l2
        for (genvar j = 0; j < P; j++) begin : g_n
            if (j == 0) begin : g_mux
                assign node[NLVL][0] = sel[SELW-1] ? node[NLVL-1][1] : node[NLVL-1][0];
            end else begin : g_zero
                assign node[NLVL][j] = '0;
            end
        end
    end

    assign y = node[NLVL][0];

endmodule

// File: rtl/mux_scan_nto1.sv
// N-to-1 channel multiplexer with registered output and an optional scan mode
// that dwells DWELL enabled cycles on each channel in turn.
module mux_scan_nto1
    import mux_pkg::*;
#(
    parameter int unsigned NCH = 8,
    parameter int unsigned W = 1,
    parameter int unsigned DWELL = 4,
    localparam int unsigned SELW = clog2_min1(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] a,
    input  logic [SELW-1:0]  sel,
    input  logic             mode,
    input  logic             en,
    output logic [W-1:0]     y,
    output logic [SELW-1:0]  y_ch,
    output logic             y_valid
);

    localparam int unsigned     DCW     = clog2_min1(DWELL + 1);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
    localparam logic [DCW-1:0]  LAST_DW = DCW'(DWELL - 1);

    logic [SELW-1:0] scan_ch, scan_ch_nx, cur_c;
    logic [DCW-1:0]  dwell_cnt, dwell_cnt_nx;
    logic [W-1:0]    tree_y;
    logic            legal_c;

    assign cur_c = (mode == MODE_SCAN) ? scan_ch : sel;

    // Only a non-power-of-two channel count can produce an illegal index.
    if (NCH == (32'd1 << SELW)) begin : g_full
        assign legal_c = 1'b1;
    end else begin : g_part
        localparam logic [SELW-1:0] NCH_S = SELW'(NCH);
        assign legal_c = (cur_c < NCH_S);
    end

    mux_tree_nto1 #(
        .NCH (NCH),
        .W   (W)
    ) u_tree (
        .a   (a),
        .sel (cur_c),
        .y   (tree_y)
    );

    // Scan sequencing; leaving scan mode always restarts at channel 0.
    always_comb begin
        scan_ch_nx   = scan_ch;
        dwell_cnt_nx = dwell_cnt;
        if (mode != MODE_SCAN) begin
            scan_ch_nx   = '0;
            dwell_cnt_nx = '0;
        end else if (en) begin
            if (dwell_cnt == LAST_DW) begin
                dwell_cnt_nx = '0;
                scan_ch_nx   = (scan_ch == LAST_CH) ? '0 : scan_ch + SELW'(1);
            end else begin
                dwell_cnt_nx = dwell_cnt + DCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ch   <= '0;
            dwell_cnt <= '0;
            y         <= '0;
            y_ch      <= '0;
            y_valid   <= 1'b0;
        end else begin
            scan_ch   <= scan_ch_nx;
            dwell_cnt <= dwell_cnt_nx;
            if (en) begin
                y       <= tree_y;
                y_ch    <= cur_c;
                y_valid <= legal_c;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench for mux_scan_nto1 across three parameter sets.
module tb_mux_scan_nto1;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // u8: NCH=8 W=4 DWELL=3
    logic [31:0] a8 = '0;
    logic [2:0]  sel8 = '0;
    logic        mode8 = 1'b0, en8 = 1'b0;
    logic [3:0]  y8;
    logic [2:0]  ych8;
    logic        yv8;
    // u6: NCH=6 W=4 DWELL=4
    logic [23:0] a6 = '0;
    logic [2:0]  sel6 = '0;
    logic        mode6 = 1'b0, en6 = 1'b0;
    logic [3:0]  y6;
    logic [2:0]  ych6;
    logic        yv6;
    // u3: NCH=3 W=2 DWELL=2
    logic [5:0]  a3 = '0;
    logic [1:0]  sel3 = '0;
    logic        mode3 = 1'b0, en3 = 1'b0;
    logic [1:0]  y3;
    logic [1:0]  ych3;
    logic        yv3;

    mux_scan_nto1 #(.NCH(8), .W(4), .DWELL(3)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .sel(sel8), .mode(mode8), .en(en8),
        .y(y8), .y_ch(ych8), .y_valid(yv8));
    mux_scan_nto1 #(.NCH(6), .W(4), .DWELL(4)) u6 (
        .clk(clk), .rst_n(rst_n), .a(a6), .sel(sel6), .mode(mode6), .en(en6),
        .y(y6), .y_ch(ych6), .y_valid(yv6));
    mux_scan_nto1 #(.NCH(3), .W(2), .DWELL(2)) u3 (
        .clk(clk), .rst_n(rst_n), .a(a3), .sel(sel3), .mode(mode3), .en(en3),
        .y(y3), .y_ch(ych3), .y_valid(yv3));

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Reference model: scan position counts enabled scan edges since entry.
    int m_nch [3] = '{8, 6, 3};
    int m_dw  [3] = '{3, 4, 2};
    int m_w   [3] = '{4, 4, 2};
    int m_pos [3];
    longint m_y [3];
    longint m_ch[3];
    longint m_v [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pos[k] = 0; m_y[k] = 0; m_ch[k] = 0; m_v[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic [63:0] av, input int s,
                              input bit m, input bit e);
        int cur;
        logic [63:0] mask;
        cur  = m ? (m_pos[k] / m_dw[k]) % m_nch[k] : s;
        mask = (64'd1 << m_w[k]) - 64'd1;
        if (e) begin
            m_ch[k] = cur;
            m_v[k]  = (cur < m_nch[k]) ? 1 : 0;
            m_y[k]  = (cur < m_nch[k]) ? longint'((av >> (cur * m_w[k])) & mask) : 0;
        end else begin
            m_v[k] = 0;
        end
        if (!m) m_pos[k] = 0;
        else if (e) m_pos[k]++;
    endtask

    typedef struct {
        logic [2:0] sel;
        logic       mode;
        logic       en;
        logic [3:0] y;
        logic [2:0] ch;
        logic       v;
    } vec8_t;
    vec8_t tbl [16];

    // One u3 cycle; a3 holds value k on channel k, so y equals y_ch.
    task automatic step3(input string nm, input logic m, input logic e,
                         input int ey, input int ev);
        mode3 = m;
        en3   = e;
        @(negedge clk);
        chk({nm, ".y"}, longint'(y3), ey);
        chk({nm, ".ych"}, longint'(ych3), ey);
        chk({nm, ".v"}, longint'(yv3), ev);
    endtask

    initial begin
        tbl[0]  = '{3'd5, MODE_DIRECT, 1'b1, 4'd5, 3'd5, 1'b1};
        tbl[1]  = '{3'd2, MODE_DIRECT, 1'b1, 4'd2, 3'd2, 1'b1};
        tbl[2]  = '{3'd7, MODE_DIRECT, 1'b0, 4'd2, 3'd2, 1'b0};
        tbl[3]  = '{3'd7, MODE_DIRECT, 1'b1, 4'd7, 3'd7, 1'b1};
        tbl[4]  = '{3'd0, MODE_DIRECT, 1'b1, 4'd0, 3'd0, 1'b1};
        tbl[5]  = '{3'd3, MODE_SCAN,   1'b1, 4'd0, 3'd0, 1'b1};
        tbl[6]  = '{3'd3, MODE_SCAN,   1'b1, 4'd0, 3'd0, 1'b1};
        tbl[7]  = '{3'd3, MODE_SCAN,   1'b1, 4'd0, 3'd0, 1'b1};
        tbl[8]  = '{3'd3, MODE_SCAN,   1'b1, 4'd1, 3'd1, 1'b1};
        tbl[9]  = '{3'd4, MODE_DIRECT, 1'b1, 4'd4, 3'd4, 1'b1};
        tbl[10] = '{3'd6, MODE_SCAN,   1'b1, 4'd0, 3'd0, 1'b1};
        tbl[11] = '{3'd6, MODE_SCAN,   1'b1, 4'd0, 3'd0, 1'b1};
        tbl[12] = '{3'd6, MODE_SCAN,   1'b1, 4'd0, 3'd0, 1'b1};
        tbl[13] = '{3'd6, MODE_SCAN,   1'b1, 4'd1, 3'd1, 1'b1};
        tbl[14] = '{3'd6, MODE_SCAN,   1'b0, 4'd1, 3'd1, 1'b0};
        tbl[15] = '{3'd6, MODE_SCAN,   1'b1, 4'd1, 3'd1, 1'b1};

        a8 = 32'h7654_3210;
        a6 = 24'h54_3210;
        a3 = 6'b10_01_00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.y8", longint'(y8), 0);
        chk("rst.ych8", longint'(ych8), 0);
        chk("rst.yv8", longint'(yv8), 0);
        chk("rst.yv6", longint'(yv6), 0);
        chk("rst.yv3", longint'(yv3), 0);
        rst_n = 1'b1;

        // Direct select, enable freeze, scan and mode switch on NCH=8
        for (int i = 0; i < 16; i++) begin
            sel8  = tbl[i].sel;
            mode8 = tbl[i].mode;
            en8   = tbl[i].en;
            @(negedge clk);
            chk($sformatf("tbl%0d.y", i), longint'(y8), longint'(tbl[i].y));
            chk($sformatf("tbl%0d.ych", i), longint'(ych8), longint'(tbl[i].ch));
            chk($sformatf("tbl%0d.v", i), longint'(yv8), longint'(tbl[i].v));
        end
        en8 = 1'b0;

        // Illegal select on NCH=6
        mode6 = MODE_DIRECT; en6 = 1'b1; sel6 = 3'd7;
        @(negedge clk);
        chk("ill7.y", longint'(y6), 0);
        chk("ill7.ych", longint'(ych6), 7);
        chk("ill7.v", longint'(yv6), 0);
        sel6 = 3'd3;
        @(negedge clk);
        chk("leg3.y", longint'(y6), 3);
        chk("leg3.ych", longint'(ych6), 3);
        chk("leg3.v", longint'(yv6), 1);
        sel6 = 3'd6;
        @(negedge clk);
        chk("ill6.y", longint'(y6), 0);
        chk("ill6.ych", longint'(ych6), 6);
        chk("ill6.v", longint'(yv6), 0);
        en6 = 1'b0;

        // Scan sequence on NCH=3, DWELL=2
        sel3 = 2'd0;
        step3("scan0", MODE_SCAN, 1'b1, 0, 1);
        step3("scan1", MODE_SCAN, 1'b1, 0, 1);
        step3("scan2", MODE_SCAN, 1'b1, 1, 1);
        step3("scan3", MODE_SCAN, 1'b1, 1, 1);
        step3("scan4", MODE_SCAN, 1'b1, 2, 1);
        step3("scan5", MODE_SCAN, 1'b1, 2, 1);
        step3("scan6", MODE_SCAN, 1'b1, 0, 1);
        step3("scan7", MODE_SCAN, 1'b1, 0, 1);
        // Enable freeze after the first ch1 sample
        step3("frz_dir", MODE_DIRECT, 1'b1, 0, 1);
        step3("frz0", MODE_SCAN, 1'b1, 0, 1);
        step3("frz1", MODE_SCAN, 1'b1, 0, 1);
        step3("frz2", MODE_SCAN, 1'b1, 1, 1);
        step3("frz_h0", MODE_SCAN, 1'b0, 1, 0);
        step3("frz_h1", MODE_SCAN, 1'b0, 1, 0);
        step3("frz_h2", MODE_SCAN, 1'b0, 1, 0);
        step3("frz3", MODE_SCAN, 1'b1, 1, 1);
        step3("frz4", MODE_SCAN, 1'b1, 2, 1);
        // Asynchronous reset between edges while y_ch=2
        #2 rst_n = 1'b0;
        #1;
        chk("arst.y", longint'(y3), 0);
        chk("arst.ych", longint'(ych3), 0);
        chk("arst.v", longint'(yv3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step3("post0", MODE_SCAN, 1'b1, 0, 1);
        step3("post1", MODE_SCAN, 1'b1, 0, 1);
        step3("post2", MODE_SCAN, 1'b1, 1, 1);

        // Randomized run against the reference model
        rst_n = 1'b0;
        mode8 = 1'b0; mode6 = 1'b0; mode3 = 1'b0;
        en8 = 1'b0; en6 = 1'b0; en3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            a8 = $urandom;
            a6 = 24'($urandom);
            a3 = 6'($urandom);
            sel8 = 3'($urandom_range(7));
            sel6 = 3'($urandom_range(7));
            sel3 = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) mode8 = ~mode8;
            if ($urandom_range(7) == 0) mode6 = ~mode6;
            if ($urandom_range(7) == 0) mode3 = ~mode3;
            en8 = ($urandom_range(3) != 0);
            en6 = ($urandom_range(3) != 0);
            en3 = ($urandom_range(3) != 0);
            model_step(0, {32'b0, a8}, int'(sel8), mode8, en8);
            model_step(1, {40'b0, a6}, int'(sel6), mode6, en6);
            model_step(2, {58'b0, a3}, int'(sel3), mode3, en3);
            @(negedge clk);
            chk($sformatf("rnd%0d.y8", c), longint'(y8), m_y[0]);
            chk($sformatf("rnd%0d.ych8", c), longint'(ych8), m_ch[0]);
            chk($sformatf("rnd%0d.yv8", c), longint'(yv8), m_v[0]);
            chk($sformatf("rnd%0d.y6", c), longint'(y6), m_y[1]);
            chk($sformatf("rnd%0d.ych6", c), longint'(ych6), m_ch[1]);
            chk($sformatf("rnd%0d.yv6", c), longint'(yv6), m_v[1]);
            chk($sformatf("rnd%0d.y3", c), longint'(y3), m_y[2]);
            chk($sformatf("rnd%0d.ych3", c), longint'(ych3), m_ch[2]);
            chk($sformatf("rnd%0d.yv3", c), longint'(yv3), m_v[2]);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
